// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and widths for the data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W  : data word width
//   ADDR_W  : byte address width
//   CNT_W   : wait-state counter width (LATENCY up to 15)
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit word storage. Synchronous write, combinational read, no reset
// (contents are undefined until written).
// Ports:
//   clk   in   clock
//   we    in   write enable, sampled on the rising edge
//   addr  in   word index (shared by read and write)
//   wdata in   write data
//   rdata out  word currently stored at addr
// ---------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the CPU load/store interface. Accepts one word request
// via valid/ready, waits LATENCY cycles, performs the access on the internal
// array and returns a single-cycle response pulse.
// Ports:
//   clk        in   clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present, held stable until accepted
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_ready  out  request can be accepted this cycle (IDLE only)
//   resp_valid out  one-cycle response pulse
//   resp_rdata out  load data (0 for stores and errors)
//   resp_err   out  misaligned or out-of-range address
//   busy       out  request outstanding (pipeline stall)
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              enter_resp;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              addr_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = req_valid && (state_q == IDLE);

  // With LATENCY==0 the access happens on the accept edge itself, so the
  // request fields are used directly instead of the (not yet loaded) latches.
  assign acc_write = (state_q == IDLE) ? req_write : wr_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign addr_err = (acc_addr[1:0] != 2'b00) ||
                    (acc_addr[ADDR_W-1:AW+2] != '0);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wait_cnt_d = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Decrement only while non-zero so the counter can never wrap.
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
        if (wait_cnt_q <= CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = enter_resp && acc_write && !addr_err;

  // Response data/error are computed every cycle; outside the RESP-entry edge
  // they evaluate to 0, which clears them the cycle after the pulse.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (enter_resp) begin
      err_d = addr_err;
      if (!addr_err && !acc_write) begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench: instance A uses LATENCY=2, instance B uses LATENCY=0.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_write  (a_req_write),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .req_ready  (a_req_ready),
    .resp_valid (a_resp_valid),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err),
    .busy       (a_busy)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_write  (b_req_write),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .req_ready  (b_req_ready),
    .resp_valid (b_resp_valid),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err),
    .busy       (b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on instance A. Returns response data/error and the cycle of
  // the response pulse counted from the accept cycle (cycle 0). Leaves the
  // bench in the cycle after the pulse.
  task automatic a_xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int resp_cyc);
    int n;
    int lat;
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    n = 0;
    while (!a_req_ready && n < 20) begin
      step();
      n++;
    end
    step();
    a_req_valid = 1'b0;
    a_req_write = 1'b0;
    a_req_addr  = '0;
    a_req_wdata = '0;
    lat = 0;
    while (!a_resp_valid && lat < 20) begin
      step();
      lat++;
    end
    rdata    = a_resp_rdata;
    err      = a_resp_err;
    resp_cyc = lat + 1;
    $display("xact %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d resp_cycle=%0d",
             wr ? "ST" : "LD", addr, wdata, rdata, err, resp_cyc);
    step();
  endtask

  logic [31:0] rd;
  logic        er;
  int          rc;

  initial begin
    logic [31:0] ld_addr [4];
    logic [31:0] ld_data [4];
    int          acc [$];
    int          resp_c [$];
    logic [31:0] resp_d [$];
    int          bad;
    int          k;
    int          rv_seen;
    logic        accepted;

    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;

    // Reset state
    repeat (3) step();
    check_eq("rst_ready_in_reset", a_req_ready, 1);
    rst_n = 1'b1;
    step();
    check_eq("rst_ready", a_req_ready, 1);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_resp_valid", a_resp_valid, 0);
    check_eq("rst_resp_rdata", a_resp_rdata, 0);
    check_eq("rst_resp_err", a_resp_err, 0);

    // Store then load
    a_xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, rc);
    check_eq("st_resp_cycle", rc, 3);
    check_eq("st_err", er, 0);
    check_eq("st_rdata", rd, 0);
    a_xact(1'b0, 32'h0000_0010, 32'h0, rd, er, rc);
    check_eq("ld_resp_cycle", rc, 3);
    check_eq("ld_rdata", rd, 32'hDEAD_BEEF);
    check_eq("ld_err", er, 0);
    check_eq("ld_rdata_cleared", a_resp_rdata, 0);
    check_eq("ld_valid_cleared", a_resp_valid, 0);

    // Error cases
    a_xact(1'b1, 32'h0000_0000, 32'hA5A5_0000, rd, er, rc);
    a_xact(1'b0, 32'h0000_0013, 32'h0, rd, er, rc);
    check_eq("misalign_err", er, 1);
    check_eq("misalign_rdata", rd, 0);
    a_xact(1'b1, 32'h0000_0400, 32'h0000_0BAD, rd, er, rc);
    check_eq("range_err", er, 1);
    check_eq("range_rdata", rd, 0);
    check_eq("err_cleared", a_resp_err, 0);
    a_xact(1'b0, 32'h0000_0000, 32'h0, rd, er, rc);
    check_eq("range_no_write_w0", rd, 32'hA5A5_0000);
    a_xact(1'b0, 32'h0000_0010, 32'h0, rd, er, rc);
    check_eq("range_no_write_w4", rd, 32'hDEAD_BEEF);

    // Back-to-back loads with req_valid held high
    for (int i = 0; i < 4; i++) begin
      ld_addr[i] = 32'h20 + 32'(4 * i);
      ld_data[i] = 32'hC0DE_0000 + 32'(i * 16 + 3);
      a_xact(1'b1, ld_addr[i], ld_data[i], rd, er, rc);
    end
    bad = 0;
    k = 0;
    a_req_valid = 1'b1;
    a_req_write = 1'b0;
    a_req_addr  = ld_addr[0];
    for (int c = 0; c < 18; c++) begin
      if (a_resp_valid) begin
        resp_c.push_back(c);
        resp_d.push_back(a_resp_rdata);
      end
      if (c < 16 && (c % 4) != 0 && (a_req_ready || !a_busy)) bad++;
      if (c < 16 && (c % 4) == 0 && (!a_req_ready || a_busy)) bad++;
      accepted = a_req_valid && a_req_ready;
      if (accepted) acc.push_back(c);
      step();
      if (accepted) begin
        k++;
        if (k < 4) a_req_addr = ld_addr[k];
        else a_req_valid = 1'b0;
      end
    end
    $display("held loads: accepts=%0d responses=%0d bad_cycles=%0d", acc.size(), resp_c.size(), bad);
    check_eq("held_accept_count", acc.size(), 4);
    check_eq("held_resp_count", resp_c.size(), 4);
    check_eq("held_ready_busy", bad, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("held_accept_cycle", (i < acc.size()) ? acc[i] : -1, 4 * i);
      check_eq("held_resp_cycle", (i < resp_c.size()) ? resp_c[i] : -1, 4 * i + 3);
      check_eq("held_resp_data", (i < resp_d.size()) ? resp_d[i] : 32'hFFFF_FFFF, ld_data[i]);
    end

    // Reset asserted while a store waits
    a_xact(1'b1, 32'h0000_0010, 32'h1111_1111, rd, er, rc);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 32'h0000_0010;
    a_req_wdata = 32'h2222_2222;
    step();
    check_eq("rstwait_busy_before", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstwait_busy_async", a_busy, 0);
    check_eq("rstwait_ready_async", a_req_ready, 1);
    a_req_valid = 1'b0;
    a_req_write = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (a_resp_valid) rv_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (a_resp_valid) rv_seen++;
    end
    $display("reset mid-wait: responses seen=%0d", rv_seen);
    check_eq("rstwait_no_resp", rv_seen, 0);
    a_xact(1'b0, 32'h0000_0010, 32'h0, rd, er, rc);
    check_eq("rstwait_no_write", rd, 32'h1111_1111);

    // LATENCY=0 instance
    b_req_valid = 1'b1;
    b_req_write = 1'b1;
    b_req_addr  = 32'h0000_0008;
    b_req_wdata = 32'h0000_0077;
    check_eq("b_ready_idle", b_req_ready, 1);
    step();
    b_req_valid = 1'b0;
    check_eq("b_st_resp_valid", b_resp_valid, 1);
    check_eq("b_st_busy", b_busy, 1);
    $display("xact B ST addr=0x00000008 wdata=0x00000077 resp_valid=%0d", b_resp_valid);
    step();
    acc.delete();
    resp_c.delete();
    resp_d.delete();
    k = 0;
    b_req_valid = 1'b1;
    b_req_write = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (b_resp_valid) begin
        resp_c.push_back(c);
        resp_d.push_back(b_resp_rdata);
      end
      accepted = b_req_valid && b_req_ready;
      if (accepted) acc.push_back(c);
      step();
      if (accepted) begin
        k++;
        if (k >= 2) b_req_valid = 1'b0;
      end
    end
    $display("B held loads: accepts=%0d responses=%0d", acc.size(), resp_c.size());
    check_eq("b_accept_count", acc.size(), 2);
    check_eq("b_resp_count", resp_c.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check_eq("b_accept_cycle", (i < acc.size()) ? acc[i] : -1, 2 * i);
      check_eq("b_resp_cycle", (i < resp_c.size()) ? resp_c[i] : -1, 2 * i + 1);
      check_eq("b_resp_data", (i < resp_d.size()) ? resp_d[i] : 32'hFFFF_FFFF, 32'h0000_0077);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
